// File: rtl/coin_pkg.sv
// Shared types and constants for the Frogger coin spawn sequencer.
package coin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_SPAWN   = 3'd2,
    ST_ACTIVE  = 3'd3,
    ST_COLLECT = 3'd4,
    ST_EXPIRE  = 3'd5
  } coin_state_e;

  // Fibonacci taps for x^8 + x^6 + x^5 + x^4 + 1 (state bits 7,5,4,3).
  localparam logic [7:0]  LFSR_TAPS  = 8'hB8;
  localparam int unsigned COL_W      = 3;
  localparam logic [7:0]  MIN_PERIOD = 8'd32;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sc_coin_lfsr8.sv
// 8-bit Fibonacci LFSR used as the coin position/type random source.
module sc_coin_lfsr8
  import coin_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] state_o
);

  logic [7:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (en) state_d = lfsr_next(state_q);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/sc_coin_spawn_ctrl.sv
// Coin spawn/lifetime/pickup sequencer for the Frogger coin resource.
// Optional difficulty ramp (shrinking spawn period) under SC_COINSPAWN_DIFFICULTY_EN.
module sc_coin_spawn_ctrl
  import coin_pkg::*;
#(
  parameter logic [7:0] SPAWN_PERIOD  = 8'd200,
  parameter logic [7:0] LIFETIME      = 8'd150,
  parameter logic [7:0] LFSR_SEED     = 8'hA5,
  parameter logic [2:0] SCORE_NORMAL  = 3'd1,
  parameter logic [2:0] SCORE_SPECIAL = 3'd5
) (
  input  logic       SC_CoinSpawnCtrl_CLOCK_50,
  input  logic       SC_CoinSpawnCtrl_RESET_InHigh,
  input  logic       SC_CoinSpawnCtrl_start_InHigh,
  input  logic       SC_CoinSpawnCtrl_stop_InHigh,
  input  logic       SC_CoinSpawnCtrl_pause_InHigh,
  input  logic       SC_CoinSpawnCtrl_tick_InHigh,
  input  logic [2:0] SC_CoinSpawnCtrl_frogCol_In,
  input  logic       SC_CoinSpawnCtrl_frogOnRow_InHigh,
  input  logic       SC_CoinSpawnCtrl_coinType_In,
  output logic       SC_CoinSpawnCtrl_regClear_OutLow,
  output logic       SC_CoinSpawnCtrl_regLoad_OutLow,
  output logic       SC_CoinSpawnCtrl_coinValid_OutHigh,
  output logic [2:0] SC_CoinSpawnCtrl_coinCol_Out,
  output logic [2:0] SC_CoinSpawnCtrl_scoreAdd_Out,
  output logic       SC_CoinSpawnCtrl_scoreValid_OutHigh,
  output logic       SC_CoinSpawnCtrl_expired_OutHigh
);

  logic clk, rst;
  assign clk = SC_CoinSpawnCtrl_CLOCK_50;
  assign rst = SC_CoinSpawnCtrl_RESET_InHigh;

  coin_state_e state_q, state_d;
  logic [7:0]  period_q, period_d;
  logic [7:0]  life_q, life_d;
  logic [7:0]  reload_val;

  logic             reg_clear_q, reg_clear_d;
  logic             reg_load_q, reg_load_d;
  logic             coin_valid_q, coin_valid_d;
  logic [COL_W-1:0] coin_col_q, coin_col_d;
  logic [2:0]       score_add_q, score_add_d;
  logic             score_valid_q, score_valid_d;
  logic             expired_q, expired_d;

  logic [7:0] lfsr;
  logic       tick_en;
  logic       pickup;
  logic       unused_lfsr;

  sc_coin_lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .en      (1'b1),
    .state_o (lfsr)
  );

  assign unused_lfsr = ^lfsr[6:3];

`ifdef SC_COINSPAWN_DIFFICULTY_EN
  logic [7:0] reload_q, reload_d, reload_dec;

  always_comb begin
    reload_dec = (reload_q < (MIN_PERIOD + 8'd16)) ? MIN_PERIOD : (reload_q - 8'd16);
    reload_d   = reload_q;
    if (state_d == ST_IDLE)
      reload_d = SPAWN_PERIOD;
    else if (state_q == ST_ACTIVE && state_d == ST_COLLECT)
      reload_d = reload_dec;
  end

  always_ff @(posedge clk) begin
    if (rst) reload_q <= SPAWN_PERIOD;
    else     reload_q <= reload_d;
  end

  // The decrement lands on COLLECT entry, so the following WAIT already uses it.
  assign reload_val = reload_q;
`else
  assign reload_val = SPAWN_PERIOD;
`endif

  assign tick_en = SC_CoinSpawnCtrl_tick_InHigh & ~SC_CoinSpawnCtrl_pause_InHigh;
  assign pickup  = SC_CoinSpawnCtrl_frogOnRow_InHigh &&
                   (SC_CoinSpawnCtrl_frogCol_In == coin_col_q);

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    life_d   = life_q;

    case (state_q)
      ST_IDLE: begin
        if (SC_CoinSpawnCtrl_start_InHigh) begin
          state_d  = ST_WAIT;
          period_d = reload_val;
        end
      end
      ST_WAIT: begin
        if (tick_en) begin
          if (period_q == 8'd1) state_d  = ST_SPAWN;
          else                  period_d = period_q - 8'd1;
        end
      end
      ST_SPAWN: begin
        state_d = ST_ACTIVE;
        life_d  = LIFETIME;
      end
      ST_ACTIVE: begin
        if (pickup) begin
          state_d = ST_COLLECT;
        end else if (tick_en) begin
          if (life_q == 8'd1) state_d = ST_EXPIRE;
          else                life_d  = life_q - 8'd1;
        end
      end
      ST_COLLECT: begin
        state_d  = ST_WAIT;
        period_d = reload_val;
      end
      ST_EXPIRE: begin
        state_d  = ST_WAIT;
        period_d = reload_val;
      end
      default: state_d = ST_IDLE;
    endcase

    if (SC_CoinSpawnCtrl_stop_InHigh) state_d = ST_IDLE;
  end

  // Outputs are decoded from the next state so each pulse is registered and
  // coincides with its state; the type strobe is therefore low during SPAWN
  // and the coin-type register holds the new type in the first ACTIVE cycle.
  always_comb begin
    reg_clear_d   = 1'b1;
    reg_load_d    = 1'b1;
    coin_col_d    = coin_col_q;
    coin_valid_d  = (state_d == ST_ACTIVE);
    score_valid_d = (state_d == ST_COLLECT);
    score_add_d   = '0;
    expired_d     = (state_d == ST_EXPIRE);

    if (state_d == ST_SPAWN) begin
      coin_col_d = lfsr[COL_W-1:0];
      if (lfsr[7]) reg_clear_d = 1'b0;
      else         reg_load_d  = 1'b0;
    end else if (state_d == ST_IDLE) begin
      coin_col_d = '0;
    end

    if (state_d == ST_COLLECT)
      score_add_d = SC_CoinSpawnCtrl_coinType_In ? SCORE_NORMAL : SCORE_SPECIAL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      period_q      <= '0;
      life_q        <= '0;
      reg_clear_q   <= 1'b1;
      reg_load_q    <= 1'b1;
      coin_valid_q  <= 1'b0;
      coin_col_q    <= '0;
      score_add_q   <= '0;
      score_valid_q <= 1'b0;
      expired_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      period_q      <= period_d;
      life_q        <= life_d;
      reg_clear_q   <= reg_clear_d;
      reg_load_q    <= reg_load_d;
      coin_valid_q  <= coin_valid_d;
      coin_col_q    <= coin_col_d;
      score_add_q   <= score_add_d;
      score_valid_q <= score_valid_d;
      expired_q     <= expired_d;
    end
  end

  assign SC_CoinSpawnCtrl_regClear_OutLow    = reg_clear_q;
  assign SC_CoinSpawnCtrl_regLoad_OutLow     = reg_load_q;
  assign SC_CoinSpawnCtrl_coinValid_OutHigh  = coin_valid_q;
  assign SC_CoinSpawnCtrl_coinCol_Out        = coin_col_q;
  assign SC_CoinSpawnCtrl_scoreAdd_Out       = score_add_q;
  assign SC_CoinSpawnCtrl_scoreValid_OutHigh = score_valid_q;
  assign SC_CoinSpawnCtrl_expired_OutHigh    = expired_q;

endmodule
